// File: rtl/instruction_fetch.sv
// Fetch stage: PC -> imem req/ready, next-PC select, IF/ID register with one-entry skid; FETCH_PERF_CNT_EN adds counters.
// Latency: IF/ID loads on the edge after imem_ready; zero-wait memory sustains one instruction per cycle.
// Backpressure: stall freezes IF/ID, an accepted word parks in the skid and requests pause until stall drops.
module instruction_fetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_write,
    output logic [31:0] next_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] pc_plus4;
    logic [31:0] skid_instr, skid_pc_plus4;
    logic [31:0] drain_addr;
    logic        flush;
    logic        ifid_load, ifid_sel_skid, skid_load, bubble, drain_load;

    assign pc_plus4 = pc + 32'd4;
    // Keep pc_write quiet while reset is held, even if a redirect arrives.
    assign flush    = branch_taken & reset;

    always_comb begin
        state_next    = state;
        imem_req      = 1'b0;
        imem_addr     = pc;
        pc_write      = 1'b0;
        next_pc       = pc_plus4;
        ifid_load     = 1'b0;
        ifid_sel_skid = 1'b0;
        skid_load     = 1'b0;
        bubble        = 1'b0;
        drain_load    = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (flush) begin
                    // An unanswered request must still complete to its original address.
                    if (!imem_ready) begin
                        drain_load = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (imem_ready && !stall) begin
                    ifid_load = 1'b1;
                    pc_write  = 1'b1;
                end else if (imem_ready) begin
                    skid_load  = 1'b1;
                    pc_write   = 1'b1;
                    state_next = HOLD;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_next = FETCH;
                end else if (!stall) begin
                    ifid_load     = 1'b1;
                    ifid_sel_skid = 1'b1;
                    state_next    = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (!flush && imem_ready)
                    state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            pc_write = 1'b1;
            next_pc  = branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid    <= 1'b0;
            if_instr    <= RESET_INSTR;
            if_pc_plus4 <= 32'd0;
        end else if (flush) begin
            if_valid <= 1'b0;
            if_instr <= RESET_INSTR;
        end else if (ifid_load) begin
            if_valid    <= 1'b1;
            if_instr    <= ifid_sel_skid ? skid_instr    : imem_rdata;
            if_pc_plus4 <= ifid_sel_skid ? skid_pc_plus4 : pc_plus4;
        end else if (bubble) begin
            if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_instr    <= 32'd0;
            skid_pc_plus4 <= 32'd0;
            drain_addr    <= 32'd0;
        end else begin
            if (flush) begin
                skid_instr    <= 32'd0;
                skid_pc_plus4 <= 32'd0;
            end else if (skid_load) begin
                skid_instr    <= imem_rdata;
                skid_pc_plus4 <= pc_plus4;
            end
            if (drain_load)
                drain_addr <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (ifid_load)
                fetch_count <= fetch_count + 32'd1;
            if (flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter register and the IF/ID boundary. It presents the current PC to instruction memory over a req/ready handshake and computes the next PC (PC+4 or a branch redirect). It also drives the PC register's write enable and holds the fetched instruction in the IF/ID register, with stall, flush and a one-entry skid buffer.

## Interface
Parameters:
- RESET_INSTR, 32'h0000_0000, value loaded into if_instr on reset and on flush (MIPS nop).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- pc  in  32  current PC from the PC register output
- pc_write  out  1  write enable to the PC register
- next_pc  out  32  next value for the PC register
- branch_taken  in  1  redirect request from later stage; pulse, one cycle
- branch_target  in  32  redirect address, valid with branch_taken
- stall  in  1  decode cannot accept a new IF/ID entry this cycle
- imem_req  out  1  instruction memory request
- imem_addr  out  32  instruction memory address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory response valid (may be same cycle as req)
- imem_rdata  in  32  instruction word, valid with imem_ready
- if_valid  out  1  IF/ID entry holds a real instruction
- if_instr  out  32  IF/ID instruction
- if_pc_plus4  out  32  IF/ID PC+4 of that instruction

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Reset state IDLE.
- IDLE: imem_req=0, pc_write=0; next edge -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, next_pc=pc+4 (mod 2^32, wraps FFFF_FFFC -> 0).
  - ready & !stall: IF/ID <= {1, imem_rdata, pc+4}; pc_write=1; stay FETCH.
  - ready & stall: skid <= {imem_rdata, pc+4}; pc_write=1; IF/ID held; -> HOLD.
  - !ready & !stall: if_valid <= 0 (bubble); pc_write=0.
  - !ready & stall: IF/ID held; pc_write=0.
- HOLD: imem_req=0, pc_write=0. When !stall: IF/ID <= {1, skid}; -> FETCH.
- DRAIN: imem_req=1, imem_addr=drain_addr (latched). Response discarded. On ready -> FETCH. pc_write=0.
- Flush (branch_taken=1) has priority over everything, including stall:
  - next_pc=branch_target, pc_write=1.
  - if_valid <= 0, if_instr <= RESET_INSTR; skid discarded.
  - From FETCH with !ready: drain_addr <= pc; -> DRAIN. From FETCH with ready, HOLD or IDLE: -> FETCH; any same-cycle imem_rdata dropped.
  - In DRAIN: branch_target still taken, stay DRAIN.
- stall never clears if_valid; it only freezes IF/ID.

## Timing
- Reset values: if_valid=0, if_instr=RESET_INSTR, if_pc_plus4=0, skid=0, state=IDLE; imem_req=0 and pc_write=0 while reset low.
- imem_req, imem_addr, pc_write, next_pc are combinational from state and inputs; IF/ID and skid are registered.
- First request one cycle after reset release.
- Zero-wait memory: one instruction per cycle. Fetch-to-IF/ID latency: 1 edge after ready.
- N-wait memory: N bubbles per instruction, PC held.
- Reset asserted mid-request: request abandoned immediately; memory must tolerate imem_req dropping.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count (32) and flush_count (32).
  - fetch_count increments each edge IF/ID loads a valid instruction.
  - flush_count increments each cycle branch_taken=1.
  - Both wrap at 2^32 and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, zero-wait memory returning pc as data, pc 0 -> 4 -> 8: if_instr 0,4,8 on consecutive edges, if_pc_plus4 4,8,12, pc_write=1 each cycle.
- 2-wait memory at pc=0x40: imem_addr stays 0x40 for 3 cycles, if_valid=0 for 2 edges, then if_instr=data, if_pc_plus4=0x44.
- stall high while ready at pc=0x10: pc_write=1 once, state HOLD, imem_req=0; stall low -> if_instr=mem[0x10], if_pc_plus4=0x14; no duplicate fetch.
- branch_taken with target 0x200 while 2-wait request to 0x80 outstanding: pc_write=1, next_pc=0x200, imem_addr stays 0x80 until ready. The 0x80 data never reaches IF/ID. The next request is to 0x200.
- branch_taken and stall same cycle: flush wins, if_valid=0, if_instr=RESET_INSTR.
- pc=FFFF_FFFC: next_pc=0, if_pc_plus4=0. With FETCH_PERF_CNT_EN, fetch_count equals the number of valid IF/ID loads.
